// File: rtl/wb_pkg.sv
// Shared write-back definitions: source encodings,
// datapath widths and the register-file port bundle.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    WB_SRC_MEM = 2'd0,
    WB_SRC_ALU = 2'd1,
    WB_SRC_PC2 = 2'd2,
    WB_SRC_RSV = 2'd3
  } wbSrc_e;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbPort_t;

  localparam wbPort_t WB_PORT_IDLE = '{
    we:   1'b0,
    addr: '0,
    data: '0
  };

endpackage

// File: rtl/wb_src_mux.sv
// Write-back source selector: load data, ALU
// result or link value; reserved code yields zero.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] memData,
  input  logic [W-1:0] aluData,
  input  logic [W-1:0] pcData,
  output logic [W-1:0] selData
);

  // pick the write-back value for this cycle
  always_comb begin
    selData = '0;
    unique case (1'b1)
      (sel == WB_SRC_MEM): selData = memData;
      (sel == WB_SRC_ALU): selData = aluData;
      (sel == WB_SRC_PC2): selData = pcData;
      (sel == WB_SRC_RSV): selData = '0;
      default:             selData = '0;
    endcase
  end

endmodule

// File: rtl/write_stage.sv
// Write-back stage: selects the result source and
// registers the register-file write port.
module write_stage
  import wb_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWrite,
  input  logic [1:0]    RegStore,
  input  logic [DW-1:0] IPCP2,
  input  logic [DW-1:0] ALUResult,
  input  logic [DW-1:0] StoreMem,
  input  logic [AW-1:0] rdWB,
  output logic [DW-1:0] loadData,
  output logic [AW-1:0] loadAddr,
  output logic          regWriteOut
);

  logic [DW-1:0] selData;
  logic [DW-1:0] dataQ;
  logic [AW-1:0] addrQ;
  logic          weQ;

  wb_src_mux #(
    .W(DW)
  ) uMux (
    .sel    (RegStore),
    .memData(StoreMem),
    .aluData(ALUResult),
    .pcData (IPCP2),
    .selData(selData)
  );

  // capture the write port; low reset drops it
  always_ff @(posedge clk) begin
    if (!reset) begin
      dataQ <= '0;
      addrQ <= '0;
      weQ   <= 1'b0;
    end else begin
      dataQ <= selData;
      addrQ <= rdWB;
      weQ   <= RegWrite;
    end
  end

  assign loadData    = dataQ;
  assign loadAddr    = addrQ;
  assign regWriteOut = weQ;

endmodule

// File: tb/tb_write_stage.sv
// Directed checks of the write-back stage:
// reset, every source, latency, mid-stream reset.
module tb_write_stage;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [1:0]  RegStore;
  logic [15:0] IPCP2;
  logic [15:0] ALUResult;
  logic [15:0] StoreMem;
  logic [2:0]  rdWB;
  logic [15:0] loadData;
  logic [2:0]  loadAddr;
  logic        regWriteOut;

  int passed = 0;
  int total  = 0;

  write_stage dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .RegStore   (RegStore),
    .IPCP2      (IPCP2),
    .ALUResult  (ALUResult),
    .StoreMem   (StoreMem),
    .rdWB       (rdWB),
    .loadData   (loadData),
    .loadAddr   (loadAddr),
    .regWriteOut(regWriteOut)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic chkAll(
    input string       tag,
    input logic [15:0] d,
    input logic [2:0]  a,
    input logic        w
  );
    chk({tag, ".data"}, loadData, d);
    chk({tag, ".addr"}, {13'd0, loadAddr}, {13'd0, a});
    chk({tag, ".we"}, {15'd0, regWriteOut}, {15'd0, w});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RegWrite  = 1'b1;
    ALUResult = 16'hAAAA;
    StoreMem  = 16'hBBBB;
    IPCP2     = 16'hCCCC;
    rdWB      = 3'd5;
    reset     = 1'b0;
    RegStore  = 2'd1;

    step();
    chkAll("reset", 16'h0000, 3'd0, 1'b0);

    reset = 1'b1;
    step();
    chkAll("alu", 16'hAAAA, 3'd5, 1'b1);

    RegStore = 2'd0;
    step();
    chkAll("mem", 16'hBBBB, 3'd5, 1'b1);

    RegStore = 2'd2;
    step();
    chkAll("link", 16'hCCCC, 3'd5, 1'b1);

    RegStore = 2'd3;
    RegWrite = 1'b0;
    #10;
    chkAll("hold", 16'hCCCC, 3'd5, 1'b1);
    step();
    chkAll("rsv", 16'h0000, 3'd5, 1'b0);

    RegStore = 2'd1;
    RegWrite = 1'b1;
    reset    = 1'b0;
    step();
    chkAll("midrst", 16'h0000, 3'd0, 1'b0);
    step();
    chkAll("rsthold", 16'h0000, 3'd0, 1'b0);

    reset     = 1'b1;
    rdWB      = 3'd0;
    ALUResult = 16'h1234;
    step();
    chkAll("rd0", 16'h1234, 3'd0, 1'b1);

    rdWB     = 3'd7;
    RegStore = 2'd0;
    StoreMem = 16'hFFFF;
    step();
    chkAll("rd7", 16'hFFFF, 3'd7, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
